// File: rtl/wshb_arbiter.sv
// Two-master Wishbone arbiter sharing one SDRAM controller slave port (m0 = VGA reader, m1 = pixel writer).
// Define WSHB_ARB_FAIR_EN for round-robin ties and MAX_BURST handover on both masters; default gives m0 priority.
module wshb_arbiter #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int MAX_BURST = 16
) (
   input  logic                  clk,
   input  logic                  nrst,

   input  logic                  m0_cyc,
   input  logic                  m0_stb,
   input  logic                  m0_we,
   input  logic [ADDR_W-1:0]     m0_adr,
   input  logic [DATA_W-1:0]     m0_dat_w,
   input  logic [DATA_W/8-1:0]   m0_sel,
   output logic                  m0_ack,
   output logic [DATA_W-1:0]     m0_dat_r,

   input  logic                  m1_cyc,
   input  logic                  m1_stb,
   input  logic                  m1_we,
   input  logic [ADDR_W-1:0]     m1_adr,
   input  logic [DATA_W-1:0]     m1_dat_w,
   input  logic [DATA_W/8-1:0]   m1_sel,
   output logic                  m1_ack,
   output logic [DATA_W-1:0]     m1_dat_r,

   output logic                  s_cyc,
   output logic                  s_stb,
   output logic                  s_we,
   output logic [ADDR_W-1:0]     s_adr,
   output logic [DATA_W-1:0]     s_dat_w,
   output logic [DATA_W/8-1:0]   s_sel,
   input  logic                  s_ack,
   input  logic [DATA_W-1:0]     s_dat_r,

   output logic [1:0]            grant
);

   localparam int CNT_W = ($clog2(MAX_BURST + 1) > 5) ? $clog2(MAX_BURST + 1) : 5;
   localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t            r_state;
   logic [1:0]        r_grant;
   logic [CNT_W-1:0]  r_burstCnt;

   logic [CNT_W-1:0]  w_cntInc;
   logic              w_limitHit0;
   logic              w_limitHit1;
   logic              w_tieToM1;

   // Saturating increment: an owner left alone keeps the count pinned at MAX_BURST.
   always_comb begin
      w_cntInc = (r_burstCnt >= BURST_MAX) ? BURST_MAX : r_burstCnt + 1'b1;
   end

   assign w_limitHit1 = s_ack && (w_cntInc == BURST_MAX);

`ifdef WSHB_ARB_FAIR_EN
   logic r_lastServed;

   assign w_limitHit0 = s_ack && (w_cntInc == BURST_MAX);
   assign w_tieToM1   = !r_lastServed;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_lastServed <= 1'b1;
      end else if (r_grant[0]) begin
         r_lastServed <= 1'b0;
      end else if (r_grant[1]) begin
         r_lastServed <= 1'b1;
      end
   end
`else
   // Master 0 is never cut short so a VGA line fetch is not interrupted.
   assign w_limitHit0 = 1'b0;
   assign w_tieToM1   = 1'b0;
`endif

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state    <= IDLE;
         r_grant    <= 2'b00;
         r_burstCnt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (m0_cyc && (!m1_cyc || !w_tieToM1)) begin
                  r_state    <= GNT0;
                  r_grant    <= 2'b01;
                  r_burstCnt <= '0;
               end else if (m1_cyc) begin
                  r_state    <= GNT1;
                  r_grant    <= 2'b10;
                  r_burstCnt <= '0;
               end
            end
            GNT0: begin
               if (!m0_cyc) begin
                  if (m1_cyc) begin
                     r_state <= GNT1;
                     r_grant <= 2'b10;
                  end else begin
                     r_state <= IDLE;
                     r_grant <= 2'b00;
                  end
                  r_burstCnt <= '0;
               end else if (w_limitHit0 && m1_cyc) begin
                  r_state    <= GNT1;
                  r_grant    <= 2'b10;
                  r_burstCnt <= '0;
               end else if (s_ack) begin
                  r_burstCnt <= w_cntInc;
               end
            end
            GNT1: begin
               if (!m1_cyc) begin
                  if (m0_cyc) begin
                     r_state <= GNT0;
                     r_grant <= 2'b01;
                  end else begin
                     r_state <= IDLE;
                     r_grant <= 2'b00;
                  end
                  r_burstCnt <= '0;
               end else if (w_limitHit1 && m0_cyc) begin
                  r_state    <= GNT0;
                  r_grant    <= 2'b01;
                  r_burstCnt <= '0;
               end else if (s_ack) begin
                  r_burstCnt <= w_cntInc;
               end
            end
            default: begin
               r_state    <= IDLE;
               r_grant    <= 2'b00;
               r_burstCnt <= '0;
            end
         endcase
      end
   end

   // Gating on nrst drops the slave bus the instant reset asserts, not at the next edge.
   always_comb begin
      s_cyc   = 1'b0;
      s_stb   = 1'b0;
      s_we    = 1'b0;
      s_adr   = '0;
      s_dat_w = '0;
      s_sel   = '0;
      m0_ack  = 1'b0;
      m1_ack  = 1'b0;
      if (nrst) begin
         case (r_state)
            GNT0: begin
               s_cyc   = m0_cyc;
               s_stb   = m0_stb;
               s_we    = m0_we;
               s_adr   = m0_adr;
               s_dat_w = m0_dat_w;
               s_sel   = m0_sel;
               m0_ack  = s_ack;
            end
            GNT1: begin
               s_cyc   = m1_cyc;
               s_stb   = m1_stb;
               s_we    = m1_we;
               s_adr   = m1_adr;
               s_dat_w = m1_dat_w;
               s_sel   = m1_sel;
               m1_ack  = s_ack;
            end
            default: begin
            end
         endcase
      end
   end

   assign m0_dat_r = s_dat_r;
   assign m1_dat_r = s_dat_r;
   assign grant    = r_grant;

endmodule

// File: tb/tb_wshb_arbiter.sv
// Self-checking bench for wshb_arbiter: directed scenarios plus randomized contention,
// checked against a transfer-level model of who gets the bus and for how many transfers.
module tb_wshb_arbiter;

   localparam int DATA_W    = 32;
   localparam int ADDR_W    = 32;
   localparam int MAX_BURST = 4;
   localparam int BUDGET    = 2000;
`ifdef WSHB_ARB_FAIR_EN
   localparam bit FAIR       = 1'b1;
   localparam int BURST10_RUNS = 6;
`else
   localparam bit FAIR       = 1'b0;
   localparam int BURST10_RUNS = 2;
`endif

   logic                clk;
   logic                nrst;
   logic                m0_cyc, m0_stb, m0_we, m0_ack;
   logic [ADDR_W-1:0]   m0_adr;
   logic [DATA_W-1:0]   m0_dat_w, m0_dat_r;
   logic [DATA_W/8-1:0] m0_sel;
   logic                m1_cyc, m1_stb, m1_we, m1_ack;
   logic [ADDR_W-1:0]   m1_adr;
   logic [DATA_W-1:0]   m1_dat_w, m1_dat_r;
   logic [DATA_W/8-1:0] m1_sel;
   logic                s_cyc, s_stb, s_we, s_ack;
   logic [ADDR_W-1:0]   s_adr;
   logic [DATA_W-1:0]   s_dat_w, s_dat_r;
   logic [DATA_W/8-1:0] s_sel;
   logic [1:0]          grant;

   int checkCount = 0;
   int passCount  = 0;
   int lastServed;
   int expOwner[$];
   int expLen[$];
   int obsOwner[$];
   int obsLen[$];

   wshb_arbiter #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST)
   ) dut (
      .clk(clk), .nrst(nrst),
      .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
      .m0_dat_w(m0_dat_w), .m0_sel(m0_sel), .m0_ack(m0_ack), .m0_dat_r(m0_dat_r),
      .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
      .m1_dat_w(m1_dat_w), .m1_sel(m1_sel), .m1_ack(m1_ack), .m1_dat_r(m1_dat_r),
      .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
      .s_dat_w(s_dat_w), .s_sel(s_sel), .s_ack(s_ack), .s_dat_r(s_dat_r),
      .grant(grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [ADDR_W-1:0] expAdr(input int k, input int idx);
      return (k == 0) ? ADDR_W'(32'h1000 + 4 * idx) : ADDR_W'(32'h100 + 4 * idx);
   endfunction

   function automatic logic [DATA_W-1:0] expWrData(input int idx);
      return DATA_W'(32'hA5A5_0000 + idx);
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Master 0 reads at 0x1000+, master 1 writes a known pattern at 0x100+.
   task automatic applyStimulus(input int k, input bit on, input int idx);
      if (k == 0) begin
         m0_cyc   = on;
         m0_stb   = on;
         m0_we    = 1'b0;
         m0_adr   = expAdr(0, idx);
         m0_dat_w = '0;
         m0_sel   = 4'hF;
      end else begin
         m1_cyc   = on;
         m1_stb   = on;
         m1_we    = 1'b1;
         m1_adr   = expAdr(1, idx);
         m1_dat_w = expWrData(idx);
         m1_sel   = 4'h3;
      end
   endtask

   task automatic applyReset();
      applyStimulus(0, 1'b0, 0);
      applyStimulus(1, 1'b0, 0);
      s_ack = 1'b0;
      nrst  = 1'b0;
      #20;
      nrst  = 1'b1;
      lastServed = 1;
   endtask

   // Model: the bus is handed out in runs; a limited owner gives up after MAX_BURST
   // transfers only if the other master still has work, otherwise it finishes everything.
   task automatic buildRuns(input int n0, input int n1, input int first);
      int r[2];
      int o;
      int other;
      int chunk;
      bit limited;
      expOwner.delete();
      expLen.delete();
      r[0] = n0;
      r[1] = n1;
      o = first;
      while (r[0] + r[1] > 0) begin
         if (r[o] == 0) o = 1 - o;
         other   = 1 - o;
         limited = FAIR || (o == 1);
         chunk   = (limited && r[other] > 0 && r[o] > MAX_BURST) ? MAX_BURST : r[o];
         expOwner.push_back(o);
         expLen.push_back(chunk);
         r[o] -= chunk;
         o = other;
      end
   endtask

   task automatic noteAck(input int k);
      if (obsOwner.size() == 0 || obsOwner[obsOwner.size() - 1] != k) begin
         obsOwner.push_back(k);
         obsLen.push_back(1);
      end else begin
         obsLen[obsLen.size() - 1] = obsLen[obsLen.size() - 1] + 1;
      end
   endtask

   task automatic runScenario(input string name, input int n0, input int n1,
                              input int lat, input bit stagger);
      int rem0, rem1, idx0, idx1, sWait, cycles, first;
      bit m0Pending, sampledStb, prevAnyAck, prevOwnerCyc;
      logic a0, a1;
      logic [1:0] g, prevG;
      first = (n0 == 0 || stagger) ? 1 : (FAIR ? 1 - lastServed : 0);
      buildRuns(n0, n1, first);
      obsOwner.delete();
      obsLen.delete();
      rem0 = n0; rem1 = n1; idx0 = 0; idx1 = 0; sWait = 0; cycles = 0;
      s_ack = 1'b0;
      s_dat_r = $urandom;
      applyStimulus(1, n1 > 0, 0);
      applyStimulus(0, (n0 > 0) && !stagger, 0);
      m0Pending = (n0 > 0) && stagger;
      prevG = grant;
      prevAnyAck = 1'b0;
      prevOwnerCyc = 1'b0;
      while ((rem0 > 0 || rem1 > 0) && cycles < BUDGET) begin
         #4;
         a0 = m0_ack;
         a1 = m1_ack;
         g  = grant;
         case (g)
            2'b00: begin
               checkOutput({name, "_idleCyc"}, s_cyc, 1'b0);
               checkOutput({name, "_idleStb"}, s_stb, 1'b0);
               checkOutput({name, "_idleAcks"}, {a0, a1}, 2'b00);
            end
            2'b01: begin
               checkOutput({name, "_g0Adr"}, s_adr, expAdr(0, idx0));
               checkOutput({name, "_g0Cyc"}, s_cyc, m0_cyc);
               checkOutput({name, "_g0M1Ack"}, a1, 1'b0);
            end
            2'b10: begin
               checkOutput({name, "_g1Adr"}, s_adr, expAdr(1, idx1));
               checkOutput({name, "_g1Cyc"}, s_cyc, m1_cyc);
               checkOutput({name, "_g1M0Ack"}, a0, 1'b0);
            end
            default: checkOutput({name, "_grantLegal"}, g, 2'b00);
         endcase
         if (a0) begin
            checkOutput({name, "_ack0We"}, s_we, 1'b0);
            checkOutput({name, "_ack0Sel"}, s_sel, 4'hF);
            checkOutput({name, "_ack0Dat"}, m0_dat_r, s_dat_r);
            noteAck(0);
         end
         if (a1) begin
            checkOutput({name, "_ack1We"}, s_we, 1'b1);
            checkOutput({name, "_ack1Sel"}, s_sel, 4'h3);
            checkOutput({name, "_ack1Wdat"}, s_dat_w, expWrData(idx1));
            checkOutput({name, "_ack1Dat"}, m1_dat_r, s_dat_r);
            noteAck(1);
         end
         if (g !== prevG)
            checkOutput({name, "_switchPoint"}, (prevG == 2'b00) || prevAnyAck || !prevOwnerCyc, 1'b1);
         prevG        = g;
         prevAnyAck   = a0 || a1;
         prevOwnerCyc = (g == 2'b01) ? m0_cyc : (g == 2'b10) ? m1_cyc : 1'b0;
         sampledStb   = s_cyc && s_stb;
         @(posedge clk);
         #1;
         cycles++;
         if (a0) begin
            rem0--;
            idx0++;
            applyStimulus(0, rem0 > 0, idx0);
         end
         if (a1) begin
            rem1--;
            idx1++;
            applyStimulus(1, rem1 > 0, idx1);
         end
         if (m0Pending) begin
            applyStimulus(0, 1'b1, 0);
            m0Pending = 1'b0;
         end
         if (s_ack) begin
            s_ack = 1'b0;
            sWait = 0;
         end else if (sampledStb) begin
            sWait++;
            if (sWait >= lat) s_ack = 1'b1;
         end
         s_dat_r = $urandom;
      end
      checkOutput({name, "_inBudget"}, cycles < BUDGET, 1'b1);
      applyStimulus(0, 1'b0, idx0);
      applyStimulus(1, 1'b0, idx1);
      s_ack = 1'b0;
      checkOutput({name, "_runCount"}, obsOwner.size(), expOwner.size());
      for (int i = 0; i < expOwner.size() && i < obsOwner.size(); i++) begin
         checkOutput($sformatf("%s_run%0d_owner", name, i), obsOwner[i], expOwner[i]);
         checkOutput($sformatf("%s_run%0d_len", name, i), obsLen[i], expLen[i]);
      end
      @(posedge clk);
      #1;
      checkOutput({name, "_idleAfter"}, grant, 2'b00);
      if (expOwner.size() > 0) lastServed = expOwner[expOwner.size() - 1];
   endtask

   initial begin
      int n0, n1, lat;
      bit stg;
      nrst  = 1'b0;
      s_ack = 1'b0;
      s_dat_r = '0;
      applyStimulus(0, 1'b0, 0);
      applyStimulus(1, 1'b0, 0);
      @(posedge clk);
      #1;

      // Reset held with both masters requesting and the slave acking.
      applyStimulus(0, 1'b1, 0);
      applyStimulus(1, 1'b1, 0);
      s_ack = 1'b1;
      #300;
      checkOutput("rstGrant", grant, 2'b00);
      checkOutput("rstSCyc", s_cyc, 1'b0);
      checkOutput("rstSStb", s_stb, 1'b0);
      checkOutput("rstAcks", {m0_ack, m1_ack}, 2'b00);
      s_ack = 1'b0;
      nrst  = 1'b1;
      lastServed = 1;
      @(posedge clk);
      #1;
      checkOutput("rstFirstGrant", grant, 2'b01);
      checkOutput("rstFirstAdr", s_adr, expAdr(0, 0));
      applyStimulus(0, 1'b0, 0);
      applyStimulus(1, 1'b0, 0);
      @(posedge clk);
      #1;
      checkOutput("rstReleaseIdle", grant, 2'b00);
      lastServed = 0;

      $display("[TB] single master writes");
      runScenario("single", 0, 4, 1, 1'b0);

      $display("[TB] contention, 10 transfers each");
      applyReset();
      runScenario("burst10", 10, 10, 1, 1'b0);
      checkOutput("burst10RunTotal", obsOwner.size(), BURST10_RUNS);

      $display("[TB] slave wait states");
      runScenario("waitStates", 3, 2, 5, 1'b1);

      $display("[TB] reset during a granted transfer");
      applyStimulus(1, 1'b1, 7);
      @(posedge clk);
      #1;
      checkOutput("midRstPreGrant", grant, 2'b10);
      checkOutput("midRstPreStb", s_stb, 1'b1);
      s_ack = 1'b1;
      #3;
      nrst = 1'b0;
      #1;
      checkOutput("midRstStb", s_stb, 1'b0);
      checkOutput("midRstCyc", s_cyc, 1'b0);
      checkOutput("midRstGrant", grant, 2'b00);
      checkOutput("midRstAck", m1_ack, 1'b0);
      s_ack = 1'b0;
      applyStimulus(1, 1'b0, 0);
      @(posedge clk);
      #1;
      nrst = 1'b1;
      lastServed = 1;

      $display("[TB] randomized contention");
      for (int t = 0; t < 16; t++) begin
         n0  = $urandom_range(0, 9);
         n1  = $urandom_range(1, 9);
         lat = $urandom_range(1, 3);
         stg = (n0 > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         #($urandom_range(0, 3) * 10);
         runScenario($sformatf("rand%0d", t), n0, n1, lat, stg);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
